// File: rtl/fft_pkg.sv
// Shared definitions for the streaming FFT datapath: component widths and a
// complex-word split/pack helper. The twiddle multiplier and the twiddle ROM
// use this package too.
package fft_pkg;

  localparam int unsigned DATA_W = 12;          // bits per real/imag component
  localparam int unsigned FRAC_W = 10;          // fractional bits, Q(12.10)
  localparam int unsigned CPLX_W = 2 * DATA_W;  // packed complex word {re, im}

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  function automatic cplx_t cplx_split(input logic [CPLX_W-1:0] word);
    cplx_t c;
    c.re = word[CPLX_W-1:DATA_W];
    c.im = word[DATA_W-1:0];
    return c;
  endfunction

  function automatic logic [CPLX_W-1:0] cplx_pack(input cplx_t c);
    return {c.re, c.im};
  endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Feedback delay line of an SDF stage: a DEPTH-deep shift register of complex
// words. head is the oldest word, i.e. the one leaving on the next shift.
//
// Ports:
//   clk       clock, rising edge
//   clr       synchronous clear of all words
//   shift_en  shift din in and advance the line by one word
//   din       word entering the line
//   head      oldest word in the line
module sdf_delay_line
  import fft_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = CPLX_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (shift_en) begin
      mem_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
    end
  end

  assign head = mem_q[DEPTH-1];

endmodule

// File: rtl/r2sdf_bfly_stage.sv
// Radix-2 single-path delay-feedback butterfly stage (decimation in frequency).
// First half of a frame (FILL) parks samples in the delay line and emits the
// previous frame's differences; second half (BFLY) emits (a+b)/2 and parks
// (a-b)/2. Outputs are registered one cycle after the accepted sample.
//
// Build option: define R2SDF_ROUND_EN for round-half-up halving instead of
// truncation toward -inf. Timing is identical in both builds.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   in_data valid; stage advances only when high
//   in_data    complex sample {re, im}, signed Q(12.10)
//   out_valid  out_data/tw_addr/tw_en valid
//   out_data   butterfly result {re, im}, to twiddle multiplier C operand
//   tw_addr    twiddle index k for W_(2*DELAY)^k
//   tw_en      1 = difference term (apply W^k), 0 = sum term (k = 0)
module r2sdf_bfly_stage #(
  parameter int unsigned DELAY  = 4,
  parameter int unsigned DATA_W = fft_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [2*DATA_W-1:0]      in_data,
  output logic                     out_valid,
  output logic [2*DATA_W-1:0]      out_data,
  output logic [$clog2(DELAY)-1:0] tw_addr,
  output logic                     tw_en
);

  localparam int unsigned CW    = 2 * DATA_W;
  localparam int unsigned AW    = $clog2(DELAY);
  localparam int unsigned CNT_W = $clog2(2 * DELAY);

`ifdef R2SDF_ROUND_EN
  localparam logic [DATA_W:0] Rnd = (DATA_W + 1)'(1);
`else
  localparam logic [DATA_W:0] Rnd = '0;
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             primed_q, primed_d;
  logic             valid_q, valid_d;
  logic [CW-1:0]    data_q, data_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             en_q, en_d;

  logic          bfly;
  logic [CW-1:0] head, line_din, sum_w, dif_w;
  logic [DATA_W:0] a_re, a_im, b_re, b_im;
  logic [DATA_W:0] sum_re, sum_im, dif_re, dif_im;

  assign bfly = cnt_q[CNT_W-1];

  // Sign-extend to DATA_W+1 so the sum/difference cannot overflow before halving.
  assign a_re = {head[CW-1], head[CW-1:DATA_W]};
  assign a_im = {head[DATA_W-1], head[DATA_W-1:0]};
  assign b_re = {in_data[CW-1], in_data[CW-1:DATA_W]};
  assign b_im = {in_data[DATA_W-1], in_data[DATA_W-1:0]};

  assign sum_re = a_re + b_re + Rnd;
  assign sum_im = a_im + b_im + Rnd;
  assign dif_re = a_re - b_re + Rnd;
  assign dif_im = a_im - b_im + Rnd;

  // Dropping bit 0 is the arithmetic shift right by one.
  assign sum_w = {sum_re[DATA_W:1], sum_im[DATA_W:1]};
  assign dif_w = {dif_re[DATA_W:1], dif_im[DATA_W:1]};

  assign line_din = bfly ? dif_w : in_data;

  sdf_delay_line #(
    .DEPTH (DELAY),
    .WIDTH (CW)
  ) u_line (
    .clk      (clk),
    .clr      (rst),
    .shift_en (in_valid),
    .din      (line_din),
    .head     (head)
  );

  always_comb begin
    cnt_d    = cnt_q;
    primed_d = primed_q;
    valid_d  = 1'b0;
    data_d   = data_q;
    addr_d   = addr_q;
    en_d     = en_q;
    if (in_valid) begin
      cnt_d = cnt_q + 1'b1;  // 2*DELAY is a power of two, so this wraps naturally
      if (cnt_q == '1) primed_d = 1'b1;
      valid_d = primed_q | bfly;
      if (bfly) begin
        data_d = sum_w;
        addr_d = '0;
        en_d   = 1'b0;
      end else begin
        data_d = head;
        addr_d = cnt_q[AW-1:0];
        en_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      primed_q <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      addr_q   <= '0;
      en_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      en_q     <= en_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign tw_addr   = addr_q;
  assign tw_en     = en_q;

endmodule

// File: tb/tb_r2sdf_bfly_stage.sv
module tb_r2sdf_bfly_stage;

  localparam int D = 4;
  localparam int W = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [2*W-1:0] in_data;
  logic          out_valid;
  logic [2*W-1:0] out_data;
  logic [1:0]    tw_addr;
  logic          tw_en;

  always #5 clk = ~clk;

  r2sdf_bfly_stage #(
    .DELAY  (D),
    .DATA_W (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .tw_addr   (tw_addr),
    .tw_en     (tw_en)
  );

  typedef struct {
    logic [2*W-1:0] data;
    logic [1:0]     addr;
    logic           en;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  string       test     = "init";

  // Frame-level reference: sums of this frame, differences of the previous frame.
  int             idx;
  bit             have_prev;
  logic [2*W-1:0] cur[2*D];
  logic [2*W-1:0] prev[D];

  function automatic int sx(input logic [W-1:0] x);
    return int'($signed(x));
  endfunction

  function automatic logic [W-1:0] half(input int v);
    int t;
    t = v;
`ifdef R2SDF_ROUND_EN
    t = t + 1;
`endif
    return W'(t >>> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s/%s observed=%0h expected=%0h", test, tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    idx       = 0;
    have_prev = 1'b0;
    q.delete();
  endtask

  task automatic step(input bit v, input logic [2*W-1:0] d);
    exp_t           e;
    bit             exp_v;
    int             j;
    logic [2*W-1:0] a;
    exp_v    = 1'b0;
    in_valid = v;
    in_data  = d;
    if (v) begin
      j      = idx;
      cur[j] = d;
      if (j < D) begin
        if (have_prev) begin
          e.data = prev[j];
          e.addr = 2'(j);
          e.en   = 1'b1;
          q.push_back(e);
          exp_v = 1'b1;
        end
      end else begin
        a      = cur[j-D];
        e.data = {half(sx(a[2*W-1:W]) + sx(d[2*W-1:W])), half(sx(a[W-1:0]) + sx(d[W-1:0]))};
        e.addr = 2'd0;
        e.en   = 1'b0;
        q.push_back(e);
        exp_v     = 1'b1;
        prev[j-D] = {half(sx(a[2*W-1:W]) - sx(d[2*W-1:W])), half(sx(a[W-1:0]) - sx(d[W-1:0]))};
      end
      idx++;
      if (idx == 2 * D) begin
        idx       = 0;
        have_prev = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
    if (exp_v && q.size() > 0) begin
      e = q.pop_front();
      check("out_data", {8'd0, out_data}, {8'd0, e.data});
      check("tw_addr", {30'd0, tw_addr}, {30'd0, e.addr});
      check("tw_en", {31'd0, tw_en}, {31'd0, e.en});
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    @(posedge clk);
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {8'd0, out_data}, 32'd0);
    check("rst_addr", {30'd0, tw_addr}, 32'd0);
    check("rst_en", {31'd0, tw_en}, 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic impulse_frames();
    step(1'b1, {12'h400, 12'h000});
    for (int i = 0; i < 7; i++) step(1'b1, '0);
    for (int i = 0; i < 8; i++) step(1'b1, '0);
  endtask

  initial begin
    logic [2*W-1:0] rnd_tab[8];
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    test = "reset";
    do_reset();

    test = "impulse";
    impulse_frames();

    test = "dc";
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, {12'h400, 12'h000});
    for (int i = 0; i < 4; i++) step(1'b1, '0);

    test = "round";
    do_reset();
    rnd_tab = '{{12'hFFD, 12'h000}, {12'h7FF, 12'h7FF}, {12'h800, 12'h800}, {12'h005, 12'hFF9},
                {12'h000, 12'h000}, {12'h7FF, 12'h7FF}, {12'h800, 12'h800}, {12'hFFA, 12'h009}};
    for (int i = 0; i < 8; i++) step(1'b1, rnd_tab[i]);
    for (int i = 0; i < 4; i++) step(1'b1, '0);

    test = "stall";
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, {12'h400, 12'h000});
      step(1'b0, 24'($urandom));
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, '0);
      step(1'b0, 24'($urandom));
    end

    test = "midreset";
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 24'($urandom));
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 24'($urandom);
    @(posedge clk);
    #1;
    check("mid_valid", {31'd0, out_valid}, 32'd0);
    check("mid_data", {8'd0, out_data}, 32'd0);
    rst = 1'b0;
    model_reset();
    impulse_frames();

    test = "b2b";
    do_reset();
    for (int i = 0; i < 3 * 2 * D; i++) step(1'b1, 24'($urandom));
    for (int i = 0; i < D; i++) step(1'b1, '0);
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
